// File: rtl/ps2_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ps2_pkg : shared types, frame constants and parity helper for PS/2   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package ps2_pkg;

  typedef enum logic [1:0] {
    PS2_IDLE   = 2'd0,
    PS2_DATA   = 2'd1,
    PS2_PARITY = 2'd2,
    PS2_STOP   = 2'd3
  } ps2_state_t;

  localparam int PS2_DATA_BITS  = 8;
  localparam int PS2_FRAME_BITS = 11;

  // Parity bit that makes data plus parity carry an odd number of ones.
  function automatic logic ps2_odd_parity(input logic [PS2_DATA_BITS-1:0] data);
    return ~(^data);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_sync_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ps2_sync_fifo : single-clock first-word-fall-through FIFO            |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module ps2_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign empty     = (r_count == '0);
  assign full      = (r_count == (AW+1)'(DEPTH));
  assign w_do_pop  = pop & ~empty;
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign w_do_push = push & (~full | w_do_pop);

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      r_count <= r_count + {{AW{1'b0}}, w_do_push} - {{AW{1'b0}}, w_do_pop};
    end
  end

  assign rdata = empty ? '0 : r_mem[r_rd_ptr];
  assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/ps2_rx_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ps2_rx_fifo : PS/2 device-to-host receiver with checked, buffered    |
// |               bytes and per-class error pulses                       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module ps2_rx_fifo
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int FIFO_DEPTH     = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          scl,
  input  logic                          sda,
  output logic [7:0]                    data_out,
  output logic                          data_valid,
  input  logic                          data_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          err_parity,
  output logic                          err_frame,
  output logic                          err_timeout,
  output logic                          err_overflow
);

  localparam int FCW = $clog2(FILTER_LEN + 1);
  localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int BCW = $clog2(PS2_FRAME_BITS);

  logic [1:0] w_raw;
  logic [1:0] w_filt;

  assign w_raw = {sda, scl};

  // Index 0 conditions scl, index 1 conditions sda.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_cond
      logic           r_s1;
      logic           r_s2;
      logic           r_f;
      logic [FCW-1:0] r_cnt;

      always_ff @(posedge clk) begin
        if (rst) begin
          r_s1  <= 1'b1;
          r_s2  <= 1'b1;
          r_f   <= 1'b1;
          r_cnt <= '0;
        end else begin
          r_s1 <= w_raw[gi];
          r_s2 <= r_s1;
          if (r_s2 == r_f) begin
            r_cnt <= '0;
          end else if (r_cnt == FCW'(FILTER_LEN - 1)) begin
            r_f   <= r_s2;
            r_cnt <= '0;
          end else begin
            r_cnt <= r_cnt + FCW'(1);
          end
        end
      end

      assign w_filt[gi] = r_f;
    end
  endgenerate

  logic                     r_scl_prev;
  logic                     w_strobe;
  logic                     w_sda_f;
  ps2_state_t               r_state;
  ps2_state_t               w_state_nxt;
  logic [BCW-1:0]           r_bit_cnt;
  logic [PS2_DATA_BITS-1:0] r_shreg;
  logic                     r_parity;
  logic [WDW-1:0]           r_wd;
  logic                     w_timeout;
  logic                     r_push;
  logic                     r_err_parity;
  logic                     r_err_frame;
  logic                     r_err_timeout;
  logic                     w_full;
  logic                     w_empty;

  assign w_sda_f   = w_filt[1];
  assign w_strobe  = r_scl_prev & ~w_filt[0];
  assign w_timeout = (r_state != PS2_IDLE) && (r_wd == WDW'(TIMEOUT_CYCLES));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= PS2_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_timeout) begin
      w_state_nxt = PS2_IDLE;
    end else if (w_strobe) begin
      case (r_state)
        PS2_IDLE:   if (!w_sda_f) w_state_nxt = PS2_DATA;
        PS2_DATA:   if (r_bit_cnt == BCW'(PS2_DATA_BITS - 1)) w_state_nxt = PS2_PARITY;
        PS2_PARITY: w_state_nxt = PS2_STOP;
        PS2_STOP:   w_state_nxt = PS2_IDLE;
        default:    w_state_nxt = PS2_IDLE;
      endcase
    end
  end

  // Frame datapath; the stop-bit strobe registers exactly one outcome.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_scl_prev    <= 1'b1;
      r_bit_cnt     <= '0;
      r_shreg       <= '0;
      r_parity      <= 1'b0;
      r_push        <= 1'b0;
      r_err_parity  <= 1'b0;
      r_err_frame   <= 1'b0;
      r_err_timeout <= 1'b0;
    end else begin
      r_scl_prev    <= w_filt[0];
      r_push        <= 1'b0;
      r_err_parity  <= 1'b0;
      r_err_frame   <= 1'b0;
      r_err_timeout <= w_timeout;
      if (w_timeout) begin
        r_shreg   <= '0;
        r_bit_cnt <= '0;
      end else if (w_strobe) begin
        case (r_state)
          PS2_IDLE: begin
            if (!w_sda_f) r_bit_cnt <= '0;
          end
          PS2_DATA: begin
            r_shreg   <= {w_sda_f, r_shreg[PS2_DATA_BITS-1:1]};
            r_bit_cnt <= r_bit_cnt + BCW'(1);
          end
          PS2_PARITY: begin
            r_parity <= w_sda_f;
          end
          PS2_STOP: begin
            if (r_parity != ps2_odd_parity(r_shreg)) r_err_parity <= 1'b1;
            else if (!w_sda_f)                       r_err_frame  <= 1'b1;
            else                                     r_push       <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wd <= '0;
    end else if (r_state == PS2_IDLE || w_strobe || w_timeout) begin
      r_wd <= '0;
    end else begin
      r_wd <= r_wd + WDW'(1);
    end
  end

  ps2_sync_fifo #(
    .WIDTH (PS2_DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (r_push),
    .wdata (r_shreg),
    .pop   (data_ready),
    .rdata (data_out),
    .full  (w_full),
    .empty (w_empty),
    .count (fifo_count)
  );

  assign data_valid   = ~w_empty;
  assign err_parity   = r_err_parity;
  assign err_frame    = r_err_frame;
  assign err_timeout  = r_err_timeout;
  assign err_overflow = r_push & w_full & ~data_ready;

endmodule
`default_nettype wire

// File: tb/tb_ps2_rx_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_ps2_rx_fifo : randomized self-checking bench for ps2_rx_fifo      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_ps2_rx_fifo;

  localparam int F    = 4;
  localparam int T    = 300;
  localparam int D    = 8;
  localparam int HALF = 10;

  localparam int K_PUSH = 0;
  localparam int K_PAR  = 1;
  localparam int K_FRM  = 2;

  typedef struct {
    int         cyc;
    int         kind;
    logic [7:0] b;
  } ev_t;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  scl;
  logic                  sda;
  logic [7:0]            data_out;
  logic                  data_valid;
  logic                  data_ready;
  logic [$clog2(D):0]    fifo_count;
  logic                  err_parity;
  logic                  err_frame;
  logic                  err_timeout;
  logic                  err_overflow;

  ps2_rx_fifo #(
    .FILTER_LEN     (F),
    .TIMEOUT_CYCLES (T),
    .FIFO_DEPTH     (D)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .scl          (scl),
    .sda          (sda),
    .data_out     (data_out),
    .data_valid   (data_valid),
    .data_ready   (data_ready),
    .fifo_count   (fifo_count),
    .err_parity   (err_parity),
    .err_frame    (err_frame),
    .err_timeout  (err_timeout),
    .err_overflow (err_overflow)
  );

  always #5 clk = ~clk;

  int   cyc = 0;
  int   errs = 0;
  int   checks = 0;
  bit   chk_en = 0;
  bit   rnd_ready = 0;
  int   last_fall = 0;
  int   to_lo = -1;
  int   to_hi = -1;
  int   par_seen = 0, frm_seen = 0, ovf_seen = 0, to_seen = 0;
  ev_t  evq[$];
  logic [7:0] mq[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Reference model: frame outcomes are scheduled by the sender at the
  // cycle the spec's latency predicts; the FIFO is a plain queue.
  int  m_n;
  bit  m_pop, m_push, m_par, m_frm, m_ovf;
  ev_t m_ev;
  always @(negedge clk) begin
    if (chk_en) begin
      m_n = mq.size();
      m_push = 0; m_par = 0; m_frm = 0;
      if (evq.size() > 0 && evq[0].cyc < cyc) begin
        chk("event_missed", 32'(evq[0].cyc), 32'(cyc));
        void'(evq.pop_front());
      end
      if (evq.size() > 0 && evq[0].cyc == cyc) begin
        m_ev = evq.pop_front();
        m_push = (m_ev.kind == K_PUSH);
        m_par  = (m_ev.kind == K_PAR);
        m_frm  = (m_ev.kind == K_FRM);
      end
      m_pop = (m_n > 0) && data_ready;
      m_ovf = m_push && (m_n == D) && !m_pop;
      chk("data_valid", 32'(data_valid), 32'(m_n > 0));
      chk("data_out", 32'(data_out), (m_n > 0) ? 32'(mq[0]) : 32'h0);
      chk("fifo_count", 32'(fifo_count), 32'(m_n));
      chk("err_parity", 32'(err_parity), 32'(m_par));
      chk("err_frame", 32'(err_frame), 32'(m_frm));
      chk("err_overflow", 32'(err_overflow), 32'(m_ovf));
      if (err_parity) par_seen++;
      if (err_frame) frm_seen++;
      if (err_overflow) ovf_seen++;
      if (err_timeout) begin
        if (cyc >= to_lo && cyc <= to_hi) to_seen++;
        else chk("err_timeout_unexpected", 32'(err_timeout), 32'h0);
      end
      if (rst) begin
        mq.delete();
        evq.delete();
      end else begin
        if (m_pop) void'(mq.pop_front());
        if (m_push && !m_ovf) mq.push_back(m_ev.b);
      end
    end
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #2;
      if (rnd_ready) data_ready = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stp,
                            input int nbits, input bit glitch, input int gap);
    logic [10:0] fr;
    ev_t e;
    fr = {stp, par, d, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      sda = fr[i];
      tick(4);
      if (glitch) scl = 1'b0;
      tick(1);
      scl = 1'b1;
      tick(HALF - 5);
      scl = 1'b0;
      last_fall = cyc;
      if (i == 10) begin
        e.cyc = cyc + 3 + F;
        e.b   = d;
        if ((^{d, par}) != 1'b1) e.kind = K_PAR;
        else if (!stp)           e.kind = K_FRM;
        else                     e.kind = K_PUSH;
        evq.push_back(e);
      end
      tick(4);
      if (glitch) scl = 1'b1;
      tick(1);
      scl = 1'b0;
      tick(HALF - 5);
      scl = 1'b1;
    end
    sda = 1'b1;
    tick(gap);
  endtask

  task automatic good(input logic [7:0] d, input bit glitch);
    send_frame(d, ~(^d), 1'b1, 11, glitch, 12);
  endtask

  task automatic pulse_ready();
    data_ready = 1'b1;
    tick(1);
    data_ready = 1'b0;
    tick(2);
  endtask

  task automatic drain();
    data_ready = 1'b1;
    tick(D + 4);
    data_ready = 1'b0;
    tick(2);
  endtask

  initial begin
    #900000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    logic [7:0] b;
    int k;
    scl = 1'b1; sda = 1'b1; rst = 1'b1; data_ready = 1'b0;
    tick(4);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_valid", 32'(data_valid), 32'h0);
    chk("reset_data", 32'(data_out), 32'h0);
    chk("reset_count", 32'(fifo_count), 32'h0);
    chk("reset_errs", 32'({err_parity, err_frame, err_timeout, err_overflow}), 32'h0);
    chk_en = 1;
    tick(3);

    good(8'h1C, 0);
    @(negedge clk);
    chk("t1_valid", 32'(data_valid), 32'h1);
    chk("t1_data", 32'(data_out), 32'h1C);
    chk("t1_count", 32'(fifo_count), 32'h1);
    pulse_ready();

    good(8'hF0, 0);
    good(8'h1C, 0);
    @(negedge clk);
    chk("t2_count2", 32'(fifo_count), 32'h2);
    chk("t2_head_f0", 32'(data_out), 32'hF0);
    pulse_ready();
    @(negedge clk);
    chk("t2_count1", 32'(fifo_count), 32'h1);
    chk("t2_head_1c", 32'(data_out), 32'h1C);
    pulse_ready();
    @(negedge clk);
    chk("t2_empty", 32'(data_valid), 32'h0);

    send_frame(8'h00, 1'b0, 1'b1, 11, 0, 12);
    send_frame(8'h00, 1'b1, 1'b0, 11, 0, 12);
    @(negedge clk);
    chk("t3_par_pulses", 32'(par_seen), 32'h1);
    chk("t3_frm_pulses", 32'(frm_seen), 32'h1);
    chk("t3_count", 32'(fifo_count), 32'h0);

    send_frame(8'h05, 1'b0, 1'b1, 5, 0, 2);
    to_lo = last_fall + T;
    to_hi = last_fall + T + F + 10;
    tick(T + 40);
    chk("t4_timeout_pulses", 32'(to_seen), 32'h1);
    good(8'h5A, 0);
    @(negedge clk);
    chk("t4_data_5a", 32'(data_out), 32'h5A);
    drain();

    for (int i = 0; i < 9; i++) good(8'(8'hA0 + i), 0);
    @(negedge clk);
    chk("t5_count_full", 32'(fifo_count), 32'(D));
    chk("t5_ovf_pulses", 32'(ovf_seen), 32'h1);
    chk("t5_head", 32'(data_out), 32'hA0);
    drain();

    good(8'h29, 1);
    @(negedge clk);
    chk("t6_glitch_data", 32'(data_out), 32'h29);
    drain();

    rnd_ready = 1;
    for (int i = 0; i < 40; i++) begin
      b = 8'($urandom);
      k = int'($urandom_range(0, 5));
      send_frame(b, (k == 0) ? (^b) : ~(^b), (k == 1) ? 1'b0 : 1'b1, 11,
                 bit'($urandom_range(0, 1)), int'($urandom_range(8, 30)));
    end
    rnd_ready = 0;
    drain();

    good(8'h11, 0);
    good(8'h22, 0);
    send_frame(8'h33, 1'b1, 1'b1, 6, 0, 2);
    scl = 1'b1; sda = 1'b1; rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(1);
    @(negedge clk);
    chk("t7_valid", 32'(data_valid), 32'h0);
    chk("t7_data", 32'(data_out), 32'h0);
    chk("t7_count", 32'(fifo_count), 32'h0);
    chk("t7_errs", 32'({err_parity, err_frame, err_timeout, err_overflow}), 32'h0);
    good(8'h77, 0);
    @(negedge clk);
    chk("t7_recover", 32'(data_out), 32'h77);
    drain();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
`default_nettype wire
